// File: rtl/nios2system_led_sequencer.sv
// Avalon-MM LED pattern sequencer: 8-entry table stepped at a prescaled rate.
// Optional PWM dimming of out_port is enabled with `define LED_PWM_EN.
module nios2system_led_sequencer #(
  parameter int LED_W = 10,
  parameter int PRESC_W = 24,
  parameter logic [PRESC_W-1:0] PRESC_RST = 24'd5_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] out_port
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t state, state_d;
  logic [2:0] idx, idx_d;
  logic [PRESC_W-1:0] tick, tick_d;
  logic [PRESC_W-1:0] prescale;
  logic [LED_W-1:0] manual;
  logic [LED_W-1:0] tbl [8];
  logic run, loop, done;
  logic [2:0] last;
  logic set_done, clr_run;
  logic [LED_W-1:0] sel, out_d;

  logic wr, wr_ctrl, wr_stat, wr_pre, wr_man, wr_tbl;
  assign wr = chipselect && !write_n;
  assign wr_ctrl = wr && (address == 4'd0);
  assign wr_stat = wr && (address == 4'd1);
  assign wr_pre = wr && (address == 4'd2);
  assign wr_man = wr && (address == 4'd3);
  assign wr_tbl = wr && address[3];

  always_comb begin
    state_d = state;
    idx_d = idx;
    tick_d = tick;
    set_done = 1'b0;
    clr_run = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_ctrl && writedata[0]) begin
          state_d = RUN;
          idx_d = '0;
          tick_d = prescale;
        end
      end
      RUN: begin
        if (wr_ctrl) begin
          state_d = writedata[0] ? RUN : IDLE;
          idx_d = '0;
          tick_d = prescale;
        end else if (tick == '0) begin
          tick_d = prescale;
          if (idx < last) begin
            idx_d = idx + 3'd1;
          end else if (loop) begin
            idx_d = '0;
          end else begin
            state_d = HOLD;
            idx_d = last;
            set_done = 1'b1;
            clr_run = 1'b1;
          end
        end else begin
          tick_d = tick - 1'b1;
        end
      end
      HOLD: begin
        if (wr_ctrl) begin
          state_d = writedata[0] ? RUN : IDLE;
          idx_d = '0;
          tick_d = prescale;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select from next-cycle values so out_port lags a change by one cycle
  always_comb begin
    if (state_d == IDLE) begin
      sel = wr_man ? writedata[LED_W-1:0] : manual;
    end else if (wr_tbl && (address[2:0] == idx_d)) begin
      sel = writedata[LED_W-1:0];
    end else begin
      sel = tbl[idx_d];
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pcnt, duty;
  logic wr_duty;
  assign wr_duty = wr && (address == 4'd4);
  assign out_d = sel & {LED_W{pcnt < duty}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      duty <= 8'd255;
    end else begin
      pcnt <= (pcnt == 8'd254) ? 8'd0 : pcnt + 8'd1;
      if (wr_duty) duty <= writedata[7:0];
    end
  end
`else
  assign out_d = sel;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      tick <= '0;
      out_port <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      tick <= tick_d;
      out_port <= out_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run <= 1'b0;
      loop <= 1'b0;
      last <= '0;
      done <= 1'b0;
      prescale <= PRESC_RST;
      manual <= '0;
      for (int i = 0; i < 8; i++) tbl[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        run <= writedata[0];
        loop <= writedata[1];
        last <= writedata[6:4];
      end else if (clr_run) begin
        run <= 1'b0;
      end
      if (set_done) done <= 1'b1;
      else if (wr_stat && writedata[8]) done <= 1'b0;
      if (wr_pre) prescale <= writedata[PRESC_W-1:0];
      if (wr_man) manual <= writedata[LED_W-1:0];
      if (wr_tbl) tbl[address[2:0]] <= writedata[LED_W-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      4'd0: readdata = {25'd0, last, 2'd0, loop, run};
      4'd1: readdata = {23'd0, done, 1'b0, idx, 3'd0, state == RUN};
      4'd2: readdata = 32'(prescale);
      4'd3: readdata = 32'(manual);
`ifdef LED_PWM_EN
      4'd4: readdata = {24'd0, duty};
`endif
      default: if (address[3]) readdata = 32'(tbl[address[2:0]]);
    endcase
  end

  logic unused_wd;
  assign unused_wd = &{1'b0, writedata[31:PRESC_W]};

endmodule

// File: doc/nios2system_led_sequencer.md
Name: nios2system_led_sequencer

Overview:
Avalon-MM slave that drives the 10-bit board LED bank from a programmable 8-entry pattern table, stepping entries at a prescaled tick rate. Supports one-shot and looping playback. Replaces direct software bit-banging of the LED PIO. Sits on the Nios II data master alongside the other PIO peripherals, with zero-wait-state reads.

Parameters:
- LED_W, 10, LED/pattern width.
- PRESC_W, 24, prescaler width in bits.
- PRESC_RST, 24'd5_000_000, PRESCALE reset value (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, unused bits zero.
- out_port  out  LED_W  registered LED drive.

Behaviour:
- Reset is asynchronous, active-low on reset_n; clock is clk.
- Register map:
  - 0 CTRL (RW): [0] run, [1] loop, [6:4] last index.
  - 1 STATUS: [0] busy (RO), [6:4] current index (RO), [8] done (sticky, write 1 to clear).
  - 2 PRESCALE (RW).
  - 3 MANUAL (RW, LED_W bits).
  - 4 DUTY (optional feature only).
  - 8–15 pattern table entries 0–7 (RW).
  - Unmapped addresses read 0; writes to them are ignored.
- Write qualifier: a write occurs when chipselect && !write_n, single cycle. Reads have no side effects.
- Reset values:
  - CTRL = 0, STATUS = 0, PRESCALE = PRESC_RST, MANUAL = 0.
  - Table entries = 0, out_port = 0.
  - State = IDLE, idx = 0, tick counter = 0.
- FSM states:
  - IDLE: out_port <= MANUAL. A write to CTRL with run=1 → RUN, idx <= 0, tick counter <= PRESCALE.
  - RUN: out_port <= table[idx]. Tick counter decrements every cycle; at 0 it reloads from PRESCALE and the sequencer advances:
    - If idx != last: idx <= idx+1.
    - If idx == last and loop=1: idx <= 0.
    - If idx == last and loop=0: → HOLD, done <= 1, CTRL.run <= 0.
  - HOLD: out_port holds table[last]. A write with run=1 → RUN from idx 0. A write with run=0 → IDLE.
- Dwell per entry is PRESCALE+1 cycles. PRESCALE=0 advances every cycle.
- Latency: out_port is registered and reflects a state, idx or table change one cycle later. The first entry appears on the cycle after the run write.
- Writing CTRL with run=0 while in RUN → IDLE the next cycle, idx <= 0. The done bit is unaffected.
- Writing CTRL with run=1 while already in RUN restarts at idx 0 and reloads the counter.
- Changing loop or last while running takes effect at the next advance. If last < idx at that advance, the sequencer takes the idx==last path.
- A new PRESCALE value is used at the next reload only.
- A table write to the displayed entry updates out_port on the next cycle.
- A done W1C write in the same cycle as a set event: the set wins.
- busy = (state == RUN).

Optional Feature:
LED_PWM_EN
- Defined:
  - Adds DUTY register at address 4, 8 bits, reset 255.
  - Adds a free-running 8-bit counter that wraps 254→0 (period 255).
  - out_port = selected value & {LED_W{cnt < DUTY}}, registered. DUTY=0 → all LEDs off; DUTY=255 → always on.
  - PWM applies in all states.
- Not defined:
  - Address 4 reads 0; writes to it are ignored.
  - out_port is the unmasked selected value.
  - No counter logic is generated.

Test Plan:
- Reset, then read all registers → PRESCALE=5000000, others 0; out_port=0. Write MANUAL=0x2AA → out_port=0x2AA on the next cycle.
- Table[0..2] = 0x001, 0x002, 0x004; PRESCALE=3; CTRL=0x21 (run, last=2, no loop) → out_port steps 001/002/004, 4 cycles each, then holds 0x004. STATUS reads 0x120; run bit clears.
- Same setup with CTRL=0x23 (loop) → sequence 001, 002, 004, 001… repeats for 3 loops; busy stays 1. Write CTRL=0 mid-entry → out_port=MANUAL the next cycle, idx=0.
- PRESCALE=0, last=7, table = 0..7 → out_port changes every cycle. Set done, then write STATUS=0x100 → done clears. Write 0x100 coincident with a completion → done stays 1.
- LED_PWM_EN defined, DUTY=64, MANUAL=0x3FF → out_port high 64 of every 255 cycles. DUTY=0 → always 0; DUTY=255 → always 0x3FF.
